// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared command codes, FSM states and grant encodings for spi_ram_arbiter
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic GNT_SPI = 1'b0;
  localparam logic GNT_LOC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPI_ACC = 2'd1,
    ST_LOC_ACC = 2'd2,
    ST_RD_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; the side not granted last wins a tie
module rr_arb2
  import spi_ram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_spi,
  input  logic req_loc,
  input  logic take,
  output logic gnt_spi,
  output logic gnt_loc
);

  logic last_gnt;

  assign gnt_spi = req_spi & (~req_loc | (last_gnt == GNT_LOC));
  assign gnt_loc = req_loc & (~req_spi | (last_gnt == GNT_SPI));

  // Reset to LOC so that SPI wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= GNT_LOC;
    end else if (take && gnt_spi) begin
      last_gnt <= GNT_SPI;
    end else if (take && gnt_loc) begin
      last_gnt <= GNT_LOC;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - SPI command decoder sharing a 256x8 RAM with a local bus; SPI_OVERRUN_FLAG_EN adds spi_ovr
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SPI_OVERRUN_FLAG_EN
  output logic              spi_ovr,
`endif
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              loc_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t              state;
  logic                rx_valid_d;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic                spi_pend;
  logic                pend_we;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;
  logic                resp_spi;
  logic                gnt_spi;
  logic                gnt_loc;

  logic       accept;
  logic [1:0] cmd;

  assign accept = rx_valid & ~rx_valid_d;
  assign cmd    = rx_data[9:8];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_spi (spi_pend),
    .req_loc (loc_req),
    .take    (state == ST_IDLE),
    .gnt_spi (gnt_spi),
    .gnt_loc (gnt_loc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rx_valid_d <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      spi_pend   <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      resp_spi   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      loc_gnt    <= 1'b0;
      loc_rdata  <= '0;
      loc_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
`ifdef SPI_OVERRUN_FLAG_EN
      spi_ovr    <= 1'b0;
`endif
    end else begin
      rx_valid_d <= rx_valid;
      loc_rvalid <= 1'b0;

      if (accept) begin
        tx_valid <= 1'b0;
        case (cmd)
          CMD_WR_ADDR: wr_addr <= rx_data[ADDR_W-1:0];
          CMD_RD_ADDR: rd_addr <= rx_data[ADDR_W-1:0];
          default: begin
            // The address is snapshotted so later address commands leave the entry alone.
            if (!spi_pend) begin
              spi_pend  <= 1'b1;
              pend_we   <= (cmd == CMD_WR_DATA);
              pend_addr <= (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
              pend_data <= rx_data[DATA_W-1:0];
            end
`ifdef SPI_OVERRUN_FLAG_EN
            else begin
              spi_ovr <= 1'b1;
            end
`endif
          end
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (gnt_spi) begin
            mem_en   <= 1'b1;
            mem_we   <= pend_we;
            mem_addr <= pend_addr;
            mem_din  <= pend_data;
            resp_spi <= 1'b1;
            state    <= ST_SPI_ACC;
          end else if (gnt_loc) begin
            mem_en   <= 1'b1;
            mem_we   <= loc_we;
            mem_addr <= loc_addr;
            mem_din  <= loc_wdata;
            loc_gnt  <= 1'b1;
            resp_spi <= 1'b0;
            state    <= ST_LOC_ACC;
          end
        end
        ST_SPI_ACC: begin
          spi_pend <= 1'b0;
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          state    <= mem_we ? ST_IDLE : ST_RD_RESP;
        end
        ST_LOC_ACC: begin
          loc_gnt  <= 1'b0;
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          state    <= mem_we ? ST_IDLE : ST_RD_RESP;
        end
        default: begin
          if (resp_spi) begin
            tx_data  <= mem_dout;
            tx_valid <= 1'b1;
          end else begin
            loc_rdata  <= mem_dout;
            loc_rvalid <= 1'b1;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - scoreboard bench for spi_ram_arbiter; build with SPI_OVERRUN_FLAG_EN to cover spi_ovr
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       loc_req = 1'b0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = '0;
`ifdef SPI_OVERRUN_FLAG_EN
  logic       spi_ovr;
`endif

  typedef struct {
    logic       we;
    logic       loc;
    logic [7:0] addr;
    logic [7:0] din;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] ram[256];
  logic [7:0] model[256];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SPI_OVERRUN_FLAG_EN
    .spi_ovr    (spi_ovr),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .loc_req    (loc_req),
    .loc_we     (loc_we),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .loc_gnt    (loc_gnt),
    .loc_rdata  (loc_rdata),
    .loc_rvalid (loc_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 8'h00;
      model[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  // Every RAM access cycle is matched against the next expected access.
  always @(negedge clk) begin
    if (rst_n && mem_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL mem_access unexpected: we=%0b addr=%02h din=%02h, required none", mem_we, mem_addr, mem_din);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || loc_gnt !== e.loc ||
            (e.we && mem_din !== e.din)) begin
          miscompares++;
          $display("FAIL mem_access: we=%0b addr=%02h din=%02h gnt=%0b, required we=%0b addr=%02h din=%02h gnt=%0b",
                   mem_we, mem_addr, mem_din, loc_gnt, e.we, e.addr, e.din, e.loc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic push(input logic we, input logic loc, input logic [7:0] a, input logic [7:0] d);
    acc_t e;
    e.we = we; e.loc = loc; e.addr = a; e.din = d;
    exp_q.push_back(e);
    if (we) model[a] = d;
  endtask

  task automatic spi_cmd(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    rx_data  = {c, d};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drained: %0d accesses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic loc_access(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n;
    logic [7:0] exp_rd;
    exp_rd = model[a];
    @(negedge clk);
    loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    n = 0;
    while (!loc_gnt && n < 30) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!loc_gnt) begin
      miscompares++;
      $display("FAIL loc_gnt_timeout: gnt=%0b, required 1", loc_gnt);
    end
    loc_req = 1'b0;
    if (!we) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!loc_rvalid && n < 10);
      vectors++;
      if (loc_rvalid !== 1'b1 || n != 2 || loc_rdata !== exp_rd) begin
        miscompares++;
        $display("FAIL loc_read: rvalid=%0b lat=%0d rdata=%02h, required 1 2 %02h", loc_rvalid, n, loc_rdata, exp_rd);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_valid, loc_gnt, loc_rvalid, mem_en, mem_we} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: %05b, required 00000", {tx_valid, loc_gnt, loc_rvalid, mem_en, mem_we});
    end
    vectors++;
    if ({tx_data, loc_rdata, mem_addr, mem_din} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: %08h, required 00000000", {tx_data, loc_rdata, mem_addr, mem_din});
    end
`ifdef SPI_OVERRUN_FLAG_EN
    vectors++;
    if (spi_ovr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovr: %0b, required 0", spi_ovr);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (mem_en !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: mem_en=%0b tx_valid=%0b, required 0 0", mem_en, tx_valid);
    end
  endtask

  task automatic test_spi_write_read();
    int n;
    spi_cmd(2'b00, 8'h3A);
    push(1'b1, 1'b0, 8'h3A, 8'hC5);
    spi_cmd(2'b01, 8'hC5);
    settle();
    spi_cmd(2'b10, 8'h3A);
    push(1'b0, 1'b0, 8'h3A, 8'h00);
    spi_cmd(2'b11, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 10);
    vectors++;
    if (tx_valid !== 1'b1 || n != 3 || tx_data !== 8'hC5) begin
      miscompares++;
      $display("FAIL spi_read: tx_valid=%0b lat=%0d tx_data=%02h, required 1 3 c5", tx_valid, n, tx_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_valid_hold: %0b, required 1", tx_valid);
    end
    spi_cmd(2'b00, 8'h00);
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_valid_clear: %0b, required 0", tx_valid);
    end
    settle();
  endtask

  task automatic test_arbitration();
    do_reset();
    push(1'b1, 1'b0, 8'h00, 8'h5A);
    push(1'b1, 1'b1, 8'h50, 8'h77);
    fork
      spi_cmd(2'b01, 8'h5A);
      begin @(negedge clk); loc_access(1'b1, 8'h50, 8'h77); end
    join
    settle();
    push(1'b1, 1'b0, 8'h00, 8'h11);
    spi_cmd(2'b01, 8'h11);
    settle();
    push(1'b1, 1'b1, 8'h51, 8'h88);
    push(1'b1, 1'b0, 8'h00, 8'h6B);
    fork
      spi_cmd(2'b01, 8'h6B);
      begin @(negedge clk); loc_access(1'b1, 8'h51, 8'h88); end
    join
    settle();
  endtask

  task automatic test_level();
    spi_cmd(2'b00, 8'h20);
    push(1'b1, 1'b0, 8'h20, 8'h11);
    @(negedge clk);
    rx_data  = {2'b01, 8'h11};
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    settle();
  endtask

  task automatic test_overrun();
    spi_cmd(2'b00, 8'h40);
    push(1'b0, 1'b1, 8'h3A, 8'h00);
    push(1'b1, 1'b0, 8'h40, 8'hAA);
    fork
      loc_access(1'b0, 8'h3A, 8'h00);
      begin
        @(negedge clk);
        spi_cmd(2'b01, 8'hAA);
        spi_cmd(2'b01, 8'hBB);
      end
    join
    settle();
`ifdef SPI_OVERRUN_FLAG_EN
    vectors++;
    if (spi_ovr !== 1'b1) begin
      miscompares++;
      $display("FAIL spi_ovr_set: %0b, required 1", spi_ovr);
    end
`endif
    push(1'b0, 1'b1, 8'h40, 8'h00);
    loc_access(1'b0, 8'h40, 8'h00);
    settle();
  endtask

  task automatic test_reset_mid_op();
    spi_cmd(2'b10, 8'h3A);
    push(1'b0, 1'b0, 8'h3A, 8'h00);
    spi_cmd(2'b11, 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_en, tx_valid, loc_gnt, loc_rvalid} !== 4'b0 || {tx_data, mem_addr} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid_op: flags=%04b tx_data=%02h mem_addr=%02h, required 0000 00 00",
               {mem_en, tx_valid, loc_gnt, loc_rvalid}, tx_data, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL after_abort: tx_valid=%0b mem_en=%0b, required 0 0", tx_valid, mem_en);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_spi_write_read();
    test_arbitration();
    test_level();
    test_overrun();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
